// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op and FSM
// state encodings, default width and special-case result constants.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  // Quotient for divide-by-zero and for signed overflow at the default width.
  localparam logic [XLEN_DEF-1:0] DIV0_QUOT = {XLEN_DEF{1'b1}};
  localparam logic [XLEN_DEF-1:0] OVF_QUOT  = {1'b1, {(XLEN_DEF-1){1'b0}}};

endpackage

// File: rtl/muldiv_iter_step.sv
// One iteration of the shared datapath: shift-add for multiply (accumulator
// holds {partial, multiplier}) or restoring shift-subtract for divide
// (accumulator holds {remainder, quotient/dividend}).
module muldiv_iter_step #(
  parameter int XLEN = 32
) (
  input  logic              i_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opnd,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_diff;

  // Multiply: add the multiplicand when the next multiplier bit is set, shift right.
  assign w_sum  = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
  // Divide: trial subtract of the divisor from the left-shifted remainder.
  assign w_diff = i_acc[2*XLEN-1:XLEN-1] - {1'b0, i_opnd};

  // Select the step result; a non-negative difference restores nothing and sets a quotient bit.
  always_comb begin
    o_acc = {w_sum, i_acc[XLEN-1:1]};
    if (i_div) begin
      if (!w_diff[XLEN]) o_acc = {w_diff[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
      else               o_acc = {i_acc[2*XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/execute_muldiv_ctrl.sv
// Execute-stage sequencer for RV32M ops on the iterative mul/div datapath.
// Captures operands once, stalls F/D/E while iterating, then presents the
// sign-corrected result for one cycle.
// Optional: MULDIV_FAST_MUL_EN computes MUL* in one cycle with a hardware multiplier.
import muldiv_pkg::*;

module execute_muldiv_ctrl #(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MulDivStartE,
  input  logic [2:0]      MulDivOpE,
  input  logic [XLEN-1:0] SrcA_E,
  input  logic [XLEN-1:0] SrcB_E,
  input  logic            FlushE,
  output logic            MulDivStallE,
  output logic            MulDivDoneE,
  output logic [XLEN-1:0] MulDivResultE,
  output logic            MulDivBusy
);

  localparam logic [XLEN-1:0] W_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e     r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_opnd;
  logic [2*XLEN-1:0] r_acc, w_acc_step, w_prod;
  logic              r_negq, r_negr;

  logic              w_sa, w_sb, w_div0, w_ovf, w_fast, w_accept;
  logic [XLEN-1:0]   w_absa, w_absb, w_hi, w_lo, w_res;

  // Operand signedness depends on the op; unsigned operands are taken as-is.
  assign w_sa   = SrcA_E[XLEN-1] & (MulDivOpE == OP_MULH || MulDivOpE == OP_MULHSU ||
                                    MulDivOpE == OP_DIV  || MulDivOpE == OP_REM);
  assign w_sb   = SrcB_E[XLEN-1] & (MulDivOpE == OP_MULH || MulDivOpE == OP_DIV ||
                                    MulDivOpE == OP_REM);
  assign w_absa = w_sa ? -SrcA_E : SrcA_E;
  assign w_absb = w_sb ? -SrcB_E : SrcB_E;
  assign w_div0 = MulDivOpE[2] & (SrcB_E == '0);
  assign w_ovf  = MulDivOpE[2] & ~MulDivOpE[0] & (SrcA_E == W_MIN) & (&SrcB_E);
  assign w_accept = (r_state == ST_IDLE) & MulDivStartE & ~FlushE;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN+1:0] w_fast_prod;
  // Sign-extend each operand by one bit so one signed multiplier covers all four MUL variants.
  assign w_fast_prod = $signed({w_sa, SrcA_E}) * $signed({w_sb, SrcB_E});
  assign w_fast      = ~MulDivOpE[2];
`else
  assign w_fast      = 1'b0;
`endif

  muldiv_iter_step #(.XLEN(XLEN)) u_step (
    .i_div  (r_op[2]),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_acc_step)
  );

  // Sign fix-up: product negated as a whole; quotient and remainder negated separately.
  assign w_prod = r_negq ? -r_acc : r_acc;
  assign w_hi   = r_negr ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
  assign w_lo   = r_negq ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_res  = r_op[2] ? (r_op[1] ? w_hi : w_lo)
                          : ((r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and pipeline-facing outputs.
  always_comb begin
    w_state_nxt   = r_state;
    MulDivStallE  = 1'b0;
    MulDivDoneE   = 1'b0;
    MulDivResultE = '0;
    MulDivBusy    = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        MulDivStallE = MulDivStartE & ~FlushE & ~rst;
        if (w_accept) w_state_nxt = (w_div0 | w_ovf | w_fast) ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        MulDivStallE = ~FlushE;
        if (FlushE)                              w_state_nxt = ST_IDLE;
        else if (r_cnt == CNT_W'(XLEN - 1))      w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        if (!FlushE) begin
          MulDivDoneE   = 1'b1;
          MulDivResultE = w_res;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture at accept (special cases preload the final accumulator), iteration in CALC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_op   <= '0;
      r_opnd <= '0;
      r_acc  <= '0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
    end else if (w_accept) begin
      r_op   <= MulDivOpE;
      r_cnt  <= '0;
      r_opnd <= w_absb;
      r_negq <= w_sa ^ w_sb;
      r_negr <= w_sa;
      r_acc  <= {{XLEN{1'b0}}, w_absa};
      if (w_div0 || w_ovf || w_fast) begin
        r_negq <= 1'b0;
        r_negr <= 1'b0;
      end
      if (w_div0)     r_acc <= {SrcA_E, {XLEN{1'b1}}};
      else if (w_ovf) r_acc <= {{XLEN{1'b0}}, W_MIN};
`ifdef MULDIV_FAST_MUL_EN
      else if (w_fast) r_acc <= w_fast_prod[2*XLEN-1:0];
`endif
    end else if (r_state == ST_CALC) begin
      r_acc <= w_acc_step;
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_execute_muldiv_ctrl.sv
// Self-checking bench for execute_muldiv_ctrl: latency/arithmetic reference
// model, per-cycle comparison, directed corner cases and random traffic.
module tb_execute_muldiv_ctrl;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0, flush = 1'b0;
  logic [2:0]      op = 3'd0;
  logic [XLEN-1:0] a = '0, b = '0;
  logic            stall, done, busy;
  logic [XLEN-1:0] res;

  int n_chk = 0, n_fail = 0;

  execute_muldiv_ctrl #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .MulDivStartE(start), .MulDivOpE(op),
    .SrcA_E(a), .SrcB_E(b), .FlushE(flush),
    .MulDivStallE(stall), .MulDivDoneE(done), .MulDivResultE(res), .MulDivBusy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result from RV32M rules using plain integer arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, p;
    logic [63:0] pu;
    int          q;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    pu = {32'd0, x} * {32'd0, y};
    case (o)
      3'd0: return pu[31:0];
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'({32'd0, x} - {32'd0, x} + {32'd0, y}); return p[63:32]; end
      3'd3: return pu[63:32];
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = $signed(x) / $signed(y); return q;
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        q = $signed(x) % $signed(y); return q;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Cycles from the start cycle to the Done cycle.
  function automatic int lat_of(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2]) return 1;
`endif
    if (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
    return XLEN + 1;
  endfunction

  // Reference model: cycles remaining until Done (0 = idle) and pending result.
  int          m_left = 0;
  logic [31:0] m_res = '0;
  always @(posedge clk or posedge rst) begin
    if (rst) m_left <= 0;
    else if (m_left == 0) begin
      if (start && !flush) begin
        m_left <= lat_of(op, a, b);
        m_res  <= ref_res(op, a, b);
      end
    end else if (flush) m_left <= 0;
    else m_left <= m_left - 1;
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    logic e_stall, e_done, e_busy;
    e_busy  = !rst && m_left != 0;
    e_done  = !rst && m_left == 1 && !flush;
    e_stall = !rst && ((m_left == 0) ? (start && !flush) : (m_left > 1 && !flush));
    chk("stall", {31'd0, stall}, {31'd0, e_stall});
    chk("done",  {31'd0, done},  {31'd0, e_done});
    chk("busy",  {31'd0, busy},  {31'd0, e_busy});
    chk("result", res, e_done ? m_res : 32'd0);
  end

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op, hold it in E until Done, check latency and result literally.
  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_res, input int exp_lat);
    int n;
    @(posedge clk); #1;
    op = o; a = x; b = y; start = 1'b1; flush = 1'b0;
    n = 0;
    @(negedge clk);
    chk({nm, " stall@T"}, {31'd0, stall}, 32'd1);
    while (!done && n < 100) begin
      @(negedge clk); n++;
      a = $urandom; b = $urandom;
    end
    chk({nm, " latency"}, n, exp_lat);
    chk({nm, " value"}, res, exp_res);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  localparam int LI = XLEN + 1;
`ifdef MULDIV_FAST_MUL_EN
  localparam int LM = 1;
`else
  localparam int LM = XLEN + 1;
`endif

  initial begin
    int n, dn;
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset stall", {31'd0, stall}, 32'd0);
    chk("reset busy",  {31'd0, busy},  32'd0);
    chk("reset result", res, 32'd0);
    rst = 1'b0;

    // Pin the model with hand-computed values.
    chk("model MUL",    ref_res(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("model MULHU",  ref_res(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    chk("model MULH",   ref_res(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0000_0000);
    chk("model MULHSU", ref_res(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    chk("model DIV",    ref_res(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("model REM",    ref_res(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("model lat",    lat_of(3'd5, 32'd5, 32'd0), 32'd1);

    // Directed arithmetic and special cases.
    run_op("MUL 7*-3",   3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LM);
    run_op("MULHU -1-1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LM);
    run_op("MULH -1-1",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, LM);
    run_op("MULHSU",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LM);
    run_op("DIV -7/2",   3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LI);
    run_op("REM -7/2",   3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LI);
    run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, LI);
    run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2, LI);
    run_op("DIVU 5/0",   3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("REM 5/0",    3'd6, 32'd5, 32'd0, 32'd5, 1);
    run_op("DIV ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Flush during CALC.
    @(posedge clk); #1;
    op = 3'd5; a = 32'd1000; b = 32'd3; start = 1'b1;
    repeat (11) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush stall", {31'd0, stall}, 32'd0);
    chk("flush done",  {31'd0, done},  32'd0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("flush busy next", {31'd0, busy}, 32'd0);
    run_op("after flush", 3'd5, 32'd1000, 32'd3, 32'd333, LI);

    // Asynchronous reset mid-CALC.
    @(posedge clk); #1;
    op = 3'd4; a = 32'd77; b = 32'd5; start = 1'b1;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst stall", {31'd0, stall}, 32'd0);
    chk("rst busy",  {31'd0, busy},  32'd0);
    chk("rst done",  {31'd0, done},  32'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;

    // Back-to-back with start held: second accept at T+XLEN+2.
    @(posedge clk); #1;
    op = 3'd5; a = 32'd50; b = 32'd7; start = 1'b1;
    n = 0; dn = 0;
    @(negedge clk);
    while (dn < 2 && n < 200) begin
      @(negedge clk); n++;
      if (done) dn++;
    end
    chk("b2b 2nd done", n, 2 * XLEN + 3);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      start = ($urandom % 4) != 0;
      flush = ($urandom % 150) == 0;
      op    = 3'($urandom % 8);
      a     = pick();
      b     = pick();
      if (i == 2000) rst = 1'b1;
      else           rst = 1'b0;
    end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; rst = 1'b0;
    repeat (40) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
